// File: rtl/fetch_sequencer.sv
// ----------------------------------------------------------------------------
// fetch_sequencer
//
// Instruction fetch / execute sequencer for a small multi-cycle CPU.
// After reset it spends one cycle in IDLE, then alternates between FETCH
// (request the word at pc until the memory acknowledges) and EXEC (drive
// step 00..11 to the control unit, one step per cycle). At step 11 the
// control unit may increment pc or load a branch target. A halt request
// during EXEC parks the sequencer in HALTED until reset.
//
// Optional feature (compile-time macro FETCH_TIMEOUT_EN):
//   when defined, a 4-bit counter watches FETCH; sixteen consecutive FETCH
//   cycles without mem_ack raise fault and enter HALTED. When undefined,
//   fault is tied to 0 and FETCH waits indefinitely.
//
// Ports
//   clock          in   1   sole clock, rising edge
//   resetn         in   1   asynchronous reset, ACTIVE-HIGH despite its name
//   mem_req        out  1   fetch request (high only in FETCH)
//   mem_addr       out  8   fetch address (= pc)
//   mem_ack        in   1   mem_data valid this cycle
//   mem_data       in  16   instruction word from memory
//   instrucao      out 16   latched instruction for the control unit
//   step           out  2   execution step for the control unit
//   pc_enable      in   1   update pc at step 11
//   pc_load        in   1   1: pc <= branch_target, 0: pc <= pc + 1
//   branch_target  in   8   branch destination
//   halt           in   1   HLT decoded by the control unit
//   pc             out  8   program counter
//   halted         out  1   sequencer stopped
//   fault          out  1   fetch timeout flag
// ----------------------------------------------------------------------------
module fetch_sequencer (
    input  logic        clock,
    input  logic        resetn,
    output logic        mem_req,
    output logic [7:0]  mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_data,
    output logic [15:0] instrucao,
    output logic [1:0]  step,
    input  logic        pc_enable,
    input  logic        pc_load,
    input  logic [7:0]  branch_target,
    input  logic        halt,
    output logic [7:0]  pc,
    output logic        halted,
    output logic        fault
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_EXEC   = 2'd2,
        ST_HALTED = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [1:0]  step_q, step_d;

`ifdef FETCH_TIMEOUT_EN
    logic [3:0]  tmo_q, tmo_d;
    logic        fault_q, fault_d;
`endif

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge resetn) begin
        if (resetn) begin
            state_q <= ST_IDLE;
            pc_q    <= 8'h00;
            instr_q <= 16'h0000;
            step_q  <= 2'b00;
`ifdef FETCH_TIMEOUT_EN
            tmo_q   <= 4'd0;
            fault_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            step_q  <= step_d;
`ifdef FETCH_TIMEOUT_EN
            tmo_q   <= tmo_d;
            fault_q <= fault_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        step_d  = step_q;
`ifdef FETCH_TIMEOUT_EN
        tmo_d   = tmo_q;
        fault_d = fault_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
                step_d  = 2'b00;
`ifdef FETCH_TIMEOUT_EN
                tmo_d   = 4'd0;
`endif
            end

            ST_FETCH: begin
                if (mem_ack) begin
                    instr_d = mem_data;
                    step_d  = 2'b00;
                    state_d = ST_EXEC;
                end
`ifdef FETCH_TIMEOUT_EN
                // tmo_q counts ack-less FETCH cycles already spent; the
                // 16th one (tmo_q == 15) is the timeout.
                else if (tmo_q == 4'hF) begin
                    fault_d = 1'b1;
                    state_d = ST_HALTED;
                end else begin
                    tmo_d = tmo_q + 4'd1;
                end
`endif
            end

            ST_EXEC: begin
                // halt wins over the pc update at step 11
                if (halt) begin
                    state_d = ST_HALTED;
                end else if (step_q != 2'b11) begin
                    step_d = step_q + 2'b01;
                end else begin
                    step_d  = 2'b00;
                    state_d = ST_FETCH;
`ifdef FETCH_TIMEOUT_EN
                    tmo_d   = 4'd0;
`endif
                    if (pc_enable) begin
                        pc_d = pc_load ? branch_target : pc_q + 8'd1;
                    end
                end
            end

            ST_HALTED: begin
                state_d = ST_HALTED;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mem_req   = (state_q == ST_FETCH);
    assign mem_addr  = pc_q;
    assign pc        = pc_q;
    assign instrucao = instr_q;
    assign step      = step_q;
    assign halted    = (state_q == ST_HALTED);

`ifdef FETCH_TIMEOUT_EN
    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// ----------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Drives fetch_sequencer with directed scenarios followed by randomized
// traffic and compares every output each cycle with a reference model.
// The model tracks the position inside the instruction cycle as a single
// integer (-1 idle, 0 fetch, 1..4 exec steps, 5 halted).
// ----------------------------------------------------------------------------
module tb_fetch_sequencer;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_data = 16'h0000;
    logic [15:0] instrucao;
    logic [1:0]  step;
    logic        pc_enable = 1'b0;
    logic        pc_load = 1'b0;
    logic [7:0]  branch_target = 8'h00;
    logic        halt = 1'b0;
    logic [7:0]  pc;
    logic        halted;
    logic        fault;

    fetch_sequencer dut (
        .clock         (clock),
        .resetn        (resetn),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_data      (mem_data),
        .instrucao     (instrucao),
        .step          (step),
        .pc_enable     (pc_enable),
        .pc_load       (pc_load),
        .branch_target (branch_target),
        .halt          (halt),
        .pc            (pc),
        .halted        (halted),
        .fault         (fault)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model
    int          m_pos;
    logic [7:0]  m_pc;
    logic [15:0] m_instr;
    logic [1:0]  m_hstep;
    logic        m_fault;
    int          m_wait;
    logic        obs_req;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic logic [1:0] exp_step();
        if (m_pos >= 1 && m_pos <= 4) return 2'(m_pos - 1);
        if (m_pos == 5) return m_hstep;
        return 2'b00;
    endfunction

    task automatic model_reset();
        m_pos   = -1;
        m_pc    = 8'h00;
        m_instr = 16'h0000;
        m_hstep = 2'b00;
        m_fault = 1'b0;
        m_wait  = 0;
    endtask

    task automatic model_step(input bit ack, input logic [15:0] d, input bit en,
                              input bit ld, input logic [7:0] tgt, input bit h);
        if (m_pos == -1) begin
            m_pos  = 0;
            m_wait = 0;
        end else if (m_pos == 0) begin
            if (ack) begin
                m_instr = d;
                m_pos   = 1;
            end else begin
`ifdef FETCH_TIMEOUT_EN
                m_wait++;
                if (m_wait == 16) begin
                    m_fault = 1'b1;
                    m_hstep = 2'b00;
                    m_pos   = 5;
                end
`endif
            end
        end else if (m_pos >= 1 && m_pos <= 4) begin
            if (h) begin
                m_hstep = 2'(m_pos - 1);
                m_pos   = 5;
            end else if (m_pos < 4) begin
                m_pos++;
            end else begin
                if (en) m_pc = ld ? tgt : 8'((int'(m_pc) + 1) % 256);
                m_pos  = 0;
                m_wait = 0;
            end
        end
    endtask

    task automatic check_outputs();
        obs_req = mem_req;
        chk("pc",        pc,        m_pc);
        chk("mem_addr",  mem_addr,  m_pc);
        chk("mem_req",   mem_req,   m_pos == 0);
        chk("instrucao", instrucao, m_instr);
        chk("step",      step,      exp_step());
        chk("halted",    halted,    m_pos == 5);
        chk("fault",     fault,     m_fault);
    endtask

    // Called at posedge+1; returns at posedge+1 of the next cycle.
    task automatic cycle(input bit ack, input logic [15:0] d, input bit en,
                         input bit ld, input logic [7:0] tgt, input bit h);
        mem_ack = ack; mem_data = d; pc_enable = en;
        pc_load = ld; branch_target = tgt; halt = h;
        @(negedge clock);
        check_outputs();
        @(posedge clock);
        model_step(ack, d, en, ld, tgt, h);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(posedge clock);
        #1;
        resetn = 1'b0;
    endtask

    // One instruction from FETCH: nwait ack-less cycles, ack, four EXEC
    // cycles. Steps 00..10 carry random pc_enable/pc_load noise.
    task automatic run_instr(input int nwait, input bit en, input bit ld,
                             input logic [7:0] tgt, input int hstep);
        for (int w = 0; w < nwait; w++) cycle(0, 16'($urandom), 1'b1, 1'b1, 8'($urandom), 1'b1);
        cycle(1, 16'($urandom), 1'b1, 1'b1, 8'($urandom), 1'b1);
        for (int s = 0; s < 4; s++) begin
            if (s == 3) cycle(1'($urandom), 16'($urandom), en, ld, tgt, hstep == 3);
            else        cycle(1'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                              8'($urandom), hstep == s);
        end
    endtask

    logic [7:0] saved_pc;

    initial begin
        model_reset();
        #2;

        // Zero-wait throughput with increment
        do_reset();
        for (int c = 0; c < 12; c++) begin
            cycle(1, 16'hA000, 1'b1, 1'b0, 8'h00, 1'b0);
            chk("tput_req", obs_req, (c == 1 || c == 6 || c == 11));
        end
        chk("tput_pc", pc, 8'h02);
        chk("tput_instr", instrucao, 16'hA000);

        // Branch, branch, wrap, hold
        do_reset();
        cycle(0, 16'h0, 1'b0, 1'b0, 8'h0, 1'b0);
        run_instr(0, 1'b1, 1'b1, 8'h05, -1);
        chk("br_pc05", pc, 8'h05);
        run_instr(0, 1'b1, 1'b1, 8'h20, -1);
        chk("br_addr20", mem_addr, 8'h20);
        run_instr(0, 1'b1, 1'b1, 8'hFF, -1);
        run_instr(0, 1'b1, 1'b0, 8'h00, -1);
        chk("wrap_pc", pc, 8'h00);
        run_instr(0, 1'b0, 1'b1, 8'h44, -1);
        chk("hold_pc", pc, 8'h00);

        // Three wait states before ack
        for (int w = 0; w < 3; w++) cycle(0, 16'h1234, 1'b0, 1'b0, 8'h0, 1'b0);
        cycle(1, 16'h1234, 1'b0, 1'b0, 8'h0, 1'b0);
        chk("wait_instr", instrucao, 16'h1234);
        for (int s = 0; s < 4; s++) cycle(0, 16'hFFFF, 1'b1, 1'b0, 8'h0, 1'b0);

        // Halt at step 11 beats the pc update
        saved_pc = pc;
        run_instr(0, 1'b1, 1'b1, 8'h77, 3);
        chk("halt_flag", halted, 1'b1);
        chk("halt_pc", pc, saved_pc);
        for (int i = 0; i < 20; i++)
            cycle(1, 16'($urandom), 1'b1, 1'b1, 8'($urandom), 1'($urandom));
        chk("halt_pc_end", pc, saved_pc);

        // Reset in mid-FETCH, late ack ignored
        do_reset();
        cycle(0, 16'h0, 1'b0, 1'b0, 8'h0, 1'b0);
        run_instr(0, 1'b1, 1'b1, 8'h33, -1);
        cycle(0, 16'h0, 1'b0, 1'b0, 8'h0, 1'b0);
        do_reset();
        cycle(1, 16'hBEEF, 1'b0, 1'b0, 8'h0, 1'b0);
        chk("late_ack_instr", instrucao, 16'h0000);
        cycle(0, 16'h0, 1'b0, 1'b0, 8'h0, 1'b0);
        chk("refetch_req", obs_req, 1'b1);
        chk("refetch_addr", mem_addr, 8'h00);

        // Memory never answers
        for (int i = 0; i < 24; i++) cycle(0, 16'h0, 1'b0, 1'b0, 8'h0, 1'b0);
`ifdef FETCH_TIMEOUT_EN
        chk("tmo_fault", fault, 1'b1);
        chk("tmo_halted", halted, 1'b1);
`else
        chk("tmo_fault", fault, 1'b0);
        chk("tmo_req", mem_req, 1'b1);
`endif

        // Randomized traffic
        for (int seg = 0; seg < 6; seg++) begin
            do_reset();
            for (int i = 0; i < 150; i++) begin
                if ($urandom_range(0, 99) == 0) do_reset();
                else cycle(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom),
                           1'($urandom), 8'($urandom), $urandom_range(0, 29) == 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
